// File: rtl/rand_out_reg.sv
// rand_out_reg: output stage of the random-number unit.
// Serves RDRAND/RDSEED by assembling source bits into a 16/32/64-bit result.

package params;
    localparam int OUTREG_MAX_WIDTH = 64;
endpackage

package le_types;
    typedef enum logic {
        RDRAND = 1'b0,
        RDSEED = 1'b1
    } rand_instr_t;

    typedef enum logic [1:0] {
        _16bit = 2'b00,
        _32bit = 2'b01,
        _64bit = 2'b10
    } rand_width_t;
endpackage

module rand_out_reg
    import le_types::*;
#(
    parameter int OUTREG_MAX_WIDTH = params::OUTREG_MAX_WIDTH,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  rand_instr_t                 req_instr,
    input  rand_width_t                 req_width,
    input  logic                        drng_bit,
    input  logic                        drng_valid,
    output logic                        drng_ready,
    input  logic                        seed_bit,
    input  logic                        seed_valid,
    output logic                        seed_ready,
    input  logic                        seed_healthy,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [OUTREG_MAX_WIDTH-1:0] rsp_data,
    output logic                        rsp_ok
);

    localparam int CNT_W = $clog2(OUTREG_MAX_WIDTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        RESP    = 2'b10
    } state_t;

    state_t                      state_q, state_d;
    rand_instr_t                 instr_q, instr_d;
    rand_width_t                 width_q, width_d;
    logic [OUTREG_MAX_WIDTH-2:0] data_q, data_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]             to_cnt_q, to_cnt_d;
    logic                        req_ready_q, req_ready_d;
    logic                        drng_ready_q, drng_ready_d;
    logic                        seed_ready_q, seed_ready_d;
    logic                        rsp_valid_q, rsp_valid_d;
    logic [OUTREG_MAX_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                        rsp_ok_q, rsp_ok_d;

    logic                        width_legal;
    logic                        req_fire;
    logic                        bit_fire;
    logic                        bit_in;
    logic [OUTREG_MAX_WIDTH-1:0] shifted;
    logic [CNT_W-1:0]            bit_cnt_inc;
    logic [CNT_W-1:0]            target_bits;
    logic                        last_bit;
    logic                        timed_out;

    // Decode the requested width into a bit count; 2'b11 is illegal.
    always_comb begin
        width_legal = 1'b1;
        target_bits = CNT_W'(OUTREG_MAX_WIDTH);
        case (width_q)
            _16bit:  target_bits = CNT_W'(16);
            _32bit:  target_bits = CNT_W'(32);
            _64bit:  target_bits = CNT_W'(64);
            default: target_bits = CNT_W'(OUTREG_MAX_WIDTH);
        endcase
        case (req_width)
            _16bit, _32bit, _64bit: width_legal = 1'b1;
            default:                width_legal = 1'b0;
        endcase
    end

    // Select the active source and form the shifted data word.
    always_comb begin
        req_fire = req_valid && req_ready_q;
        if (instr_q == RDSEED) begin
            bit_fire = seed_valid && seed_ready_q;
            bit_in   = seed_bit;
        end else begin
            bit_fire = drng_valid && drng_ready_q;
            bit_in   = drng_bit;
        end
        shifted     = {data_q, bit_in};
        bit_cnt_inc = bit_cnt_q + CNT_W'(1);
        last_bit    = bit_fire && (bit_cnt_inc == target_bits);
        timed_out   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and registered-output logic for IDLE/COLLECT/RESP.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        width_d      = width_q;
        data_d       = data_q;
        bit_cnt_d    = bit_cnt_q;
        to_cnt_d     = to_cnt_q;
        req_ready_d  = req_ready_q;
        drng_ready_d = drng_ready_q;
        seed_ready_d = seed_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_ok_d     = rsp_ok_q;

        case (state_q)
            IDLE: begin
                req_ready_d  = 1'b1;
                drng_ready_d = 1'b0;
                seed_ready_d = 1'b0;
                rsp_valid_d  = 1'b0;
                rsp_data_d   = '0;
                rsp_ok_d     = 1'b0;
                if (req_fire) begin
                    instr_d     = req_instr;
                    width_d     = req_width;
                    data_d      = '0;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                    req_ready_d = 1'b0;
                    if (!width_legal ||
                        (req_instr == RDSEED && !seed_healthy)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d      = COLLECT;
                        drng_ready_d = (req_instr == RDRAND);
                        seed_ready_d = (req_instr == RDSEED);
                    end
                end
            end

            COLLECT: begin
                req_ready_d = 1'b0;
                to_cnt_d    = to_cnt_q + TO_W'(1);
                if (bit_fire) begin
                    data_d    = shifted[OUTREG_MAX_WIDTH-2:0];
                    bit_cnt_d = bit_cnt_inc;
                end
                // A final bit in the expiry cycle still counts as success.
                if (last_bit) begin
                    state_d      = RESP;
                    drng_ready_d = 1'b0;
                    seed_ready_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = shifted;
                    rsp_ok_d     = 1'b1;
                end else if (timed_out) begin
                    state_d      = RESP;
                    drng_ready_d = 1'b0;
                    seed_ready_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = '0;
                    rsp_ok_d     = 1'b0;
                end
            end

            RESP: begin
                req_ready_d  = 1'b0;
                drng_ready_d = 1'b0;
                seed_ready_d = 1'b0;
                if (rsp_valid_q && rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_ok_d    = 1'b0;
                end
            end

            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                drng_ready_d = 1'b0;
                seed_ready_d = 1'b0;
                rsp_valid_d  = 1'b0;
                rsp_data_d   = '0;
                rsp_ok_d     = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            instr_q      <= RDRAND;
            width_q      <= _16bit;
            data_q       <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            req_ready_q  <= 1'b1;
            drng_ready_q <= 1'b0;
            seed_ready_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            width_q      <= width_d;
            data_q       <= data_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            req_ready_q  <= req_ready_d;
            drng_ready_q <= drng_ready_d;
            seed_ready_q <= seed_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_ok_q     <= rsp_ok_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign drng_ready = drng_ready_q;
    assign seed_ready = seed_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_ok     = rsp_ok_q;

endmodule

// File: tb/tb_rand_out_reg.sv
// tb_rand_out_reg: directed checks of the random-number output stage.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_rand_out_reg;
    import le_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    rand_instr_t req_instr;
    rand_width_t req_width;
    logic        drng_bit;
    logic        drng_valid;
    logic        drng_ready;
    logic        seed_bit;
    logic        seed_valid;
    logic        seed_ready;
    logic        seed_healthy;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic        rsp_ok;

    int n_vec = 0;
    int n_err = 0;

    rand_out_reg #(
        .OUTREG_MAX_WIDTH(64),
        .TIMEOUT_CYCLES  (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_instr   (req_instr),
        .req_width   (req_width),
        .drng_bit    (drng_bit),
        .drng_valid  (drng_valid),
        .drng_ready  (drng_ready),
        .seed_bit    (seed_bit),
        .seed_valid  (seed_valid),
        .seed_ready  (seed_ready),
        .seed_healthy(seed_healthy),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_ok      (rsp_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge of cycle 1.
    task automatic send_req(input rand_instr_t ins, input rand_width_t w);
        req_valid = 1'b1;
        req_instr = ins;
        req_width = w;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Feed the selected source until rsp_valid or budget runs out.
    // vmode: 0 valid always, 1 valid on odd cycles, 2 never valid.
    // bmode: 0 alternating bits starting with 1, 1 all ones.
    task automatic run_collect(input rand_instr_t ins, input int vmode,
                               input int bmode, input int budget,
                               output int lat, output int xfers,
                               output int bad_ready);
        logic v;
        logic b;
        lat = -1;
        xfers = 0;
        bad_ready = 0;
        for (int c = 1; c <= budget; c++) begin
            if (rsp_valid) begin
                lat = c;
                break;
            end
            v = (vmode == 0) ? 1'b1 :
                (vmode == 1) ? ((c % 2) == 1) : 1'b0;
            b = (bmode == 0) ? ~xfers[0] : 1'b1;
            if (ins == RDRAND) begin
                drng_valid = v;
                drng_bit   = b;
                seed_valid = 1'b1;
                seed_bit   = 1'b1;
                if (drng_ready && v) xfers++;
                if (seed_ready) bad_ready++;
            end else begin
                seed_valid = v;
                seed_bit   = b;
                drng_valid = 1'b1;
                drng_bit   = 1'b1;
                if (seed_ready && v) xfers++;
                if (drng_ready) bad_ready++;
            end
            @(negedge clk);
        end
        drng_valid = 1'b0;
        seed_valid = 1'b0;
    endtask

    // Complete the response handshake and check the return to IDLE.
    task automatic take_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_idle_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_idle_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_idle_data"}, rsp_data, 64'd0);
    endtask

    int lat, xf, bad, unstable, rdy_seen;
    logic [63:0] held;

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_instr    = RDRAND;
        req_width    = _16bit;
        drng_bit     = 1'b0;
        drng_valid   = 1'b0;
        seed_bit     = 1'b0;
        seed_valid   = 1'b0;
        seed_healthy = 1'b1;
        rsp_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_outs", {59'd0, drng_ready, seed_ready, rsp_valid, rsp_ok,
                         1'b0}, 64'd0);
        chk("rst_data", rsp_data, 64'd0);

        // RDRAND 16-bit, alternating bits from 1.
        send_req(RDRAND, _16bit);
        run_collect(RDRAND, 0, 0, 40, lat, xf, bad);
        chk("r16_lat", 64'(lat), 64'd17);
        chk("r16_data", rsp_data, 64'h0000_0000_0000_AAAA);
        chk("r16_ok", 64'(rsp_ok), 64'd1);
        chk("r16_seed_ready", 64'(bad), 64'd0);
        take_rsp("r16");

        // RDSEED 64-bit, valid toggling, all ones.
        send_req(RDSEED, _64bit);
        run_collect(RDSEED, 1, 1, 200, lat, xf, bad);
        chk("s64_lat", 64'(lat), 64'd128);
        chk("s64_xfers", 64'(xf), 64'd64);
        chk("s64_data", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("s64_ok", 64'(rsp_ok), 64'd1);
        chk("s64_drng_ready", 64'(bad), 64'd0);
        take_rsp("s64");

        // RDRAND 32-bit with no keystream: timeout.
        send_req(RDRAND, _32bit);
        run_collect(RDRAND, 2, 0, 300, lat, xf, bad);
        chk("to_lat", 64'(lat), 64'd257);
        chk("to_ok", 64'(rsp_ok), 64'd0);
        chk("to_data", rsp_data, 64'd0);
        take_rsp("to");

        // Request after timeout is served normally.
        send_req(RDRAND, _16bit);
        run_collect(RDRAND, 0, 0, 40, lat, xf, bad);
        chk("after_to_lat", 64'(lat), 64'd17);
        chk("after_to_data", rsp_data, 64'h0000_0000_0000_AAAA);
        chk("after_to_ok", 64'(rsp_ok), 64'd1);
        take_rsp("after_to");

        // RDSEED with failing health test.
        seed_healthy = 1'b0;
        send_req(RDSEED, _32bit);
        run_collect(RDSEED, 0, 1, 20, lat, xf, bad);
        chk("unh_lat", 64'(lat), 64'd1);
        chk("unh_ok", 64'(rsp_ok), 64'd0);
        chk("unh_data", rsp_data, 64'd0);
        chk("unh_xfers", 64'(xf), 64'd0);
        take_rsp("unh");
        seed_healthy = 1'b1;

        // Illegal width encoding.
        send_req(RDRAND, rand_width_t'(2'b11));
        run_collect(RDRAND, 0, 1, 20, lat, xf, bad);
        chk("ill_lat", 64'(lat), 64'd1);
        chk("ill_ok", 64'(rsp_ok), 64'd0);
        chk("ill_data", rsp_data, 64'd0);
        take_rsp("ill");

        // RDRAND 32-bit with consumer back-pressure.
        send_req(RDRAND, _32bit);
        run_collect(RDRAND, 0, 0, 60, lat, xf, bad);
        chk("bp_lat", 64'(lat), 64'd33);
        chk("bp_data", rsp_data, 64'h0000_0000_AAAA_AAAA);
        held = rsp_data;
        unstable = 0;
        rdy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!rsp_valid || !rsp_ok || rsp_data !== held) unstable++;
            if (req_ready) rdy_seen++;
        end
        chk("bp_stable", 64'(unstable), 64'd0);
        chk("bp_req_ready", 64'(rdy_seen), 64'd0);
        take_rsp("bp");

        // Reset mid-collection, then a fresh 16-bit request.
        send_req(RDRAND, _64bit);
        run_collect(RDRAND, 0, 1, 20, lat, xf, bad);
        chk("mid_xfers", 64'(xf), 64'd20);
        drng_valid = 1'b1;
        drng_bit   = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drng_valid = 1'b0;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_outs", {59'd0, drng_ready, seed_ready, rsp_valid,
                             rsp_ok, 1'b0}, 64'd0);
        chk("mid_rst_data", rsp_data, 64'd0);
        send_req(RDRAND, _16bit);
        run_collect(RDRAND, 0, 0, 40, lat, xf, bad);
        chk("post_rst_lat", 64'(lat), 64'd17);
        chk("post_rst_data", rsp_data, 64'h0000_0000_0000_AAAA);
        chk("post_rst_ok", 64'(rsp_ok), 64'd1);
        take_rsp("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
